// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: state encoding, datapath select codes, opcode classes and the control-word layout shared by the controller
package arm_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, HALT
  } state_t;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] OP_DP      = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BR      = 2'b10;
  typedef struct packed {
    logic       fetch;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       done;
    logic       alu_op;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctrl_t;
endpackage

// File: rtl/ctrl_out_rom.sv
// ctrl_out_rom: state -> Moore control word lookup (i_state in, o_cw out)
module ctrl_out_rom
  import arm_ctrl_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_cw
);
  always_comb begin
    o_cw = '0;
    case (i_state)
      FETCH: begin
        o_cw.fetch      = 1'b1;
        o_cw.alu_src_a  = 1'b1;
        o_cw.alu_src_b  = SRCB_FOUR;
        o_cw.result_src = RES_ALURES;
      end
      DECODE: begin
        o_cw.alu_src_a  = 1'b1;
        o_cw.alu_src_b  = SRCB_FOUR;
        o_cw.result_src = RES_ALURES;
      end
      MEMADR: o_cw.alu_src_b = SRCB_IMM;
      MEMREAD: begin
        o_cw.adr_src    = 1'b1;
        o_cw.result_src = RES_ALUOUT;
      end
      MEMWB: begin
        o_cw.result_src = RES_RDATA;
        o_cw.reg_w      = 1'b1;
        o_cw.done       = 1'b1;
      end
      MEMWRITE: begin
        o_cw.adr_src    = 1'b1;
        o_cw.result_src = RES_ALUOUT;
        o_cw.mem_w      = 1'b1;
      end
      EXECR: begin
        o_cw.alu_src_b  = SRCB_RD2;
        o_cw.alu_op     = 1'b1;
      end
      EXECI: begin
        o_cw.alu_src_b  = SRCB_IMM;
        o_cw.alu_op     = 1'b1;
      end
      ALUWB: begin
        o_cw.result_src = RES_ALUOUT;
        o_cw.reg_w      = 1'b1;
        o_cw.done       = 1'b1;
      end
      BRANCH: begin
        o_cw.alu_src_b  = SRCB_IMM;
        o_cw.result_src = RES_ALURES;
        o_cw.branch     = 1'b1;
        o_cw.done       = 1'b1;
      end
      default: o_cw = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multicycle ARM sequencer; Op/Funct/NoWrite/MemReady in, mux selects, write strobes, InstrDone and sticky Illegal/Timeout out
module multicycle_ctrl_fsm
  import arm_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       NoWrite,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       InstrDone,
  output logic       Illegal,
  output logic       Timeout
);
  state_t     r_state;
  logic [3:0] r_wait;
  logic       r_illegal;
  logic       r_timeout;
  ctrl_t      w_cw;
  logic       w_wait_st;
  logic       w_limit;
  logic       w_ready;
  logic       w_unused;
  ctrl_out_rom u_rom (
    .i_state(r_state),
    .o_cw   (w_cw)
  );
  assign w_wait_st = r_state == FETCH || r_state == MEMREAD || r_state == MEMWRITE;
  assign w_limit   = w_wait_st && r_wait == 4'(WAIT_LIMIT);
  assign w_ready   = MemReady && !w_limit;
  assign w_unused  = ^Funct[4:1];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_wait    <= 4'd0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_wait <= (w_wait_st && !MemReady && !w_limit) ? r_wait + 4'd1 : 4'd0;
      if (w_limit) r_timeout <= 1'b1;
      if (r_state == DECODE && Op == 2'b11) r_illegal <= 1'b1;
      case (r_state)
        FETCH:        r_state <= w_limit ? HALT : MemReady ? DECODE : FETCH;
        DECODE:       r_state <= Op == OP_MEM ? MEMADR : Op == OP_BR ? BRANCH :
                                 Op == OP_DP ? (Funct[5] ? EXECI : EXECR) : HALT;
        MEMADR:       r_state <= Funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD:      r_state <= w_limit ? HALT : MemReady ? MEMWB : MEMREAD;
        MEMWRITE:     r_state <= w_limit ? HALT : MemReady ? FETCH : MEMWRITE;
        EXECR, EXECI: r_state <= NoWrite ? FETCH : ALUWB;
        MEMWB, ALUWB, BRANCH: r_state <= FETCH;
        default:      r_state <= HALT;
      endcase
    end
  end
  assign IRWrite   = !reset && w_cw.fetch && w_ready;
  assign NextPC    = IRWrite;
  assign RegW      = !reset && w_cw.reg_w;
  assign MemW      = !reset && w_cw.mem_w;
  assign Branch    = !reset && w_cw.branch;
  assign InstrDone = !reset && (w_cw.done || (r_state == MEMWRITE && w_ready) ||
                     ((r_state == EXECR || r_state == EXECI) && NoWrite));
  assign ALUOp     = w_cw.alu_op;
  assign AdrSrc    = w_cw.adr_src;
  assign ALUSrcA   = w_cw.alu_src_a;
  assign ALUSrcB   = w_cw.alu_src_b;
  assign ResultSrc = w_cw.result_src;
  assign Illegal   = r_illegal;
  assign Timeout   = r_timeout;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: plans per-instruction cycle sequences from the controller rules and checks every cycle
module tb_multicycle_ctrl_fsm;
  localparam int L = 15;
  localparam logic [14:0] ALL = '1;
  localparam logic [14:0] STROBES = 15'h7C04;
  logic clk = 1'b1;
  logic reset, MemReady, NoWrite;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, ALUSrcA, InstrDone, Illegal, Timeout;
  logic [1:0] ALUSrcB, ResultSrc;
  multicycle_ctrl_fsm #(.WAIT_LIMIT(L)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .NoWrite(NoWrite), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .InstrDone(InstrDone), .Illegal(Illegal), .Timeout(Timeout)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst, mr, nw;
    logic [1:0] op;
    logic [5:0] fn;
    logic [14:0] exp, mask;
  } cyc_t;
  cyc_t q[$];
  cyc_t cur;
  bit active = 1'b0;
  int passed = 0, total = 0, cyc = 0;
  logic m_ill, m_to, m_halt;
  logic [1:0] c_op;
  logic [5:0] c_fn;
  logic c_nw;
  logic [14:0] got;
  function automatic logic [14:0] ov(input logic ir, rw, mw, br, aop, adr, sa,
                                     input logic [1:0] sb, rs, input logic dn);
    return {ir, ir, rw, mw, br, aop, adr, sa, sb, rs, dn, m_ill, m_to};
  endfunction
  task automatic push(input logic mr, input logic [14:0] e);
    q.push_back('{1'b0, mr, c_nw, c_op, c_fn, e, ALL});
  endtask
  task automatic rst_cycle();
    q.push_back('{1'b1, 1'($urandom), c_nw, c_op, c_fn, 15'h0, STROBES});
    m_ill = 1'b0;
    m_to = 1'b0;
    m_halt = 1'b0;
  endtask
  task automatic halt_cycles(input int n);
    repeat (n) push(1'($urandom), ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
  endtask
  task automatic access(input int w, input logic [14:0] ew, input logic [14:0] er);
    for (int i = 0; i < w && i < L; i++) push(1'b0, ew);
    if (w >= L) begin
      push(1'b1, ew);
      m_to = 1'b1;
      m_halt = 1'b1;
    end else push(1'b1, er);
  endtask
  task automatic instr(input logic [1:0] op, input logic [5:0] fn, input logic nw, input int fw, input int mw);
    c_op = op;
    c_fn = fn;
    c_nw = nw;
    access(fw, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0),
               ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0));
    if (m_halt) return;
    push(1'($urandom), ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0));
    case (op)
      2'b11: begin
        m_ill = 1'b1;
        m_halt = 1'b1;
      end
      2'b10: push(1'($urandom), ov(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b1));
      2'b00: begin
        push(1'($urandom), ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, fn[5] ? 2'b01 : 2'b00, 2'b00, nw));
        if (!nw) push(1'($urandom), ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
      end
      default: begin
        push(1'($urandom), ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0));
        if (fn[0]) begin
          access(mw, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0),
                     ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0));
          if (!m_halt) push(1'($urandom), ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1));
        end else
          access(mw, ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0),
                     ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1));
      end
    endcase
  endtask
  task automatic pin(input string nm, input int g, input int w);
    total++;
    if (g == w) passed++;
    else $display("FAIL %s got %0d expected %0d", nm, g, w);
  endtask
  function automatic int count_bit(input int from, input int b);
    int n = 0;
    for (int i = from; i < q.size(); i++) n += int'(q[i].exp[b]);
    return n;
  endfunction
  always @(negedge clk) begin
    if (active) begin
      got = {IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, InstrDone, Illegal, Timeout};
      total++;
      if ((got & cur.mask) == (cur.exp & cur.mask)) passed++;
      else $display("FAIL ctrl_word cycle %0d got %h expected %h mask %h", cyc, got, cur.exp, cur.mask);
    end
  end
  initial begin
    int n, op, fw, mw;
    reset = 1'b1;
    MemReady = 1'b0;
    Op = 2'b00;
    Funct = 6'h0;
    NoWrite = 1'b0;
    m_ill = 1'b0;
    m_to = 1'b0;
    m_halt = 1'b0;
    c_op = 2'b00;
    c_fn = 6'h0;
    c_nw = 1'b0;
    rst_cycle();
    rst_cycle();
    n = q.size();
    instr(2'b00, 6'b001000, 1'b0, 0, 0);
    pin("add_len", q.size() - n, 4);
    pin("add_regw_count", count_bit(n, 12), 1);
    pin("add_done_last", int'(q[$].exp[2]), 1);
    n = q.size();
    instr(2'b01, 6'b011001, 1'b0, 0, 2);
    pin("ldr_len", q.size() - n, 7);
    pin("ldr_res_last", int'(q[$].exp[4:3]), 1);
    n = q.size();
    instr(2'b01, 6'b011000, 1'b0, 3, 0);
    pin("str_len", q.size() - n, 7);
    pin("str_irwrite_count", count_bit(n, 14), 1);
    pin("str_memw_count", count_bit(n, 11), 1);
    n = q.size();
    instr(2'b00, 6'b110101, 1'b1, 0, 0);
    pin("cmp_len", q.size() - n, 3);
    pin("cmp_srcb", int'(q[$].exp[6:5]), 1);
    pin("cmp_regw_count", count_bit(n, 12), 0);
    n = q.size();
    instr(2'b10, 6'b000000, 1'b0, 0, 0);
    pin("br_len", q.size() - n, 3);
    n = q.size();
    instr(2'b00, 6'b000000, 1'b0, L - 1, 0);
    pin("fetch_wait_below_limit_len", q.size() - n, L + 3);
    n = q.size();
    instr(2'b11, 6'b000000, 1'b0, 0, 0);
    pin("illegal_len", q.size() - n, 2);
    halt_cycles(5);
    pin("illegal_sticky", int'(q[$].exp[1]), 1);
    rst_cycle();
    n = q.size();
    instr(2'b00, 6'b000000, 1'b0, 20, 0);
    pin("fetch_timeout_len", q.size() - n, L + 1);
    halt_cycles(3);
    pin("timeout_sticky", int'(q[$].exp[0]), 1);
    rst_cycle();
    c_op = 2'b01;
    c_fn = 6'b000000;
    c_nw = 1'b0;
    push(1'b1, ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0));
    push(1'b0, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0));
    push(1'b0, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0));
    push(1'b0, ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0));
    push(1'b0, ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0));
    rst_cycle();
    instr(2'b00, 6'b001000, 1'b0, 0, 0);
    n = q.size();
    instr(2'b01, 6'b000001, 1'b0, 0, 30);
    pin("memread_timeout_len", q.size() - n, L + 4);
    halt_cycles(2);
    rst_cycle();
    for (int k = 0; k < 150; k++) begin
      op = $urandom_range(0, 19);
      op = op == 0 ? 3 : op % 3;
      fw = $urandom_range(0, 39) == 0 ? L + $urandom_range(0, 3) : $urandom_range(0, 3);
      mw = $urandom_range(0, 39) == 0 ? L + $urandom_range(0, 3) : $urandom_range(0, 3);
      instr(2'(op), 6'($urandom), 1'($urandom), fw, mw);
      if (m_halt) begin
        halt_cycles($urandom_range(1, 4));
        rst_cycle();
      end
    end
    foreach (q[i]) begin
      cur = q[i];
      cyc = i;
      reset = q[i].rst;
      MemReady = q[i].mr;
      Op = q[i].op;
      Funct = q[i].fn;
      NoWrite = q[i].nw;
      active = 1'b1;
      @(posedge clk);
      #1;
    end
    active = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
